// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operand width, op encoding and FSM states.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
            if (!any_o && req_i[pos[IW-1:0]]) begin
                any_o                 = 1'b1;
                idx_o                 = pos[IW-1:0];
                gnt_o[pos[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters; round-robin grant,
// registered operands, captured result returned with the requester ID.
//
// state    | meaning
// ST_IDLE  | waiting for a request; grant offered combinationally on req_ready
// ST_ISSUE | operands registered onto the ALU, result settling
// ST_RESP  | response held on rsp_* until rsp_ready
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    input  logic [NUM_REQ*alu_pkg::OP_W-1:0] req_sel,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic [alu_pkg::OP_W-1:0]      alu_sel,
    input  logic [DATA_W-1:0]             alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_zero,
    output logic                          busy,
    output logic [15:0]                   op_count
);
    import alu_pkg::*;

    state_e              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     gid_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [OP_W-1:0]     alu_sel_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_zero_q;
    logic [15:0]         op_count_q;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                any_valid;
    logic [DATA_W-1:0]   alu_a_d, alu_b_d;
    logic [OP_W-1:0]     alu_sel_d;

    rr_grant #(.N(NUM_REQ), .IW(ID_W)) u_rr_grant (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any_valid)
    );

    // One-hot grant selects the winner's operand slices
    always_comb begin
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_sel_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_a_d   = req_a[i*DATA_W +: DATA_W];
                alu_b_d   = req_b[i*DATA_W +: DATA_W];
                alu_sel_d = req_sel[i*OP_W +: OP_W];
            end
        end
    end

    assign req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gid_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        alu_a_q   <= alu_a_d;
                        alu_b_q   <= alu_b_d;
                        alu_sel_q <= alu_sel_d;
                        gid_q     <= gnt_idx;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rsp_data_q  <= alu_result;
                    rsp_zero_q  <= (alu_result == '0);
                    rsp_id_q    <= gid_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Pointer moves only on completion, so a stalled response keeps fairness order
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= (gid_q == ID_W'(NUM_REQ-1)) ? '0 : gid_q + 1'b1;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*3-1:0]  req_sel;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic [2:0]      alu_sel;
    logic            rsp_valid, rsp_ready, rsp_zero, busy;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic [15:0]     op_count;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int r;
        case (s)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b) + 16;
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = int'(a) * (2 ** int'(b));
            3'd6: r = int'(a) / (2 ** int'(b));
            default: r = int'(a);
        endcase
        return 4'(r % 16);
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_sel);

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_zero(rsp_zero),
        .busy(busy), .op_count(op_count)
    );

    int n_tot = 0;
    int n_bad = 0;

    // reference model state
    bit          pend [N];
    logic [3:0]  pa [N];
    logic [3:0]  pb [N];
    logic [2:0]  ps [N];
    int          ptr = 0;
    int          ocnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_a[i*DW +: DW]     = pa[i];
            req_b[i*DW +: DW]     = pb[i];
            req_sel[i*3 +: 3]     = ps[i];
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        pend[i] = 1'b1; pa[i] = a; pb[i] = b; ps[i] = s;
    endtask

    // One transaction starting at a negedge with the DUT idle; ends at the negedge after completion.
    task automatic run_txn(input int bp, output int gid);
        logic [3:0] e;
        int g;
        drive();
        #1;
        g = pick();
        gid = g;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("grant", 32'(req_ready), 32'(1 << g));
        @(posedge clk);
        @(negedge clk);
        e = alu_f(pa[g], pb[g], ps[g]);
        chk("alu_a", 32'(alu_a), 32'(pa[g]));
        chk("alu_sel", 32'(alu_sel), 32'(ps[g]));
        pend[g] = 1'b0;
        drive();
        rsp_ready = (bp == 0);
        #1;
        chk("ready_issue", 32'(req_ready), 32'd0);
        chk("valid_issue", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(e));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_zero", 32'(rsp_zero), 32'(e == 4'd0));
        chk("busy_resp", 32'(busy), 32'd1);
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(e));
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_cnt", 32'(op_count), 32'(ocnt));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ocnt = (ocnt + 1) % 65536;
        ptr  = (g + 1) % N;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(ocnt));
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int gid;
        int any;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; ps[i] = '0;
        end
        drive();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_zero", 32'(rsp_zero), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed: ADD, SUB wrap, XOR to zero, PASS
        set_req(0, 4'b0011, 4'b0001, 3'b000); run_txn(0, gid);
        set_req(2, 4'b0001, 4'b0011, 3'b001); run_txn(1, gid);
        set_req(2, 4'b0101, 4'b0101, 3'b100); run_txn(0, gid);
        set_req(3, 4'b1010, 4'b0101, 3'b111); run_txn(5, gid);

        // fairness with all requesters continuously valid (ptr now 0)
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            run_txn(0, gid);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        set_req(1, 4'd7, 4'd2, 3'b010); run_txn(0, gid);
        set_req(0, 4'd1, 4'd1, 3'b000);
        set_req(3, 4'd9, 4'd1, 3'b110); run_txn(2, gid);
        run_txn(0, gid);

        // reset while in RESP discards the transaction
        set_req(1, 4'd4, 4'd4, 3'b000);
        drive();
        @(posedge clk);
        @(negedge clk);
        pend[1] = 1'b0;
        drive();
        @(negedge clk);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(op_count), 32'd0);
        ptr = 0; ocnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(3, 4'd2, 4'd1, 3'b101);
        set_req(1, 4'd8, 4'd3, 3'b011);
        run_txn(0, gid);
        run_txn(1, gid);

        // randomized traffic with withdrawals and idle gaps
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 7) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
                end
            end
            any = 0;
            for (int i = 0; i < N; i++) if (pend[i]) any = 1;
            if (any == 0) begin
                drive();
                #1;
                chk("idle_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                chk("idle_busy", 32'(busy), 32'd0);
                set_req(int'($urandom_range(0, N-1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            end
            run_txn(int'($urandom_range(0, 3)), gid);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
